// File: rtl/rc_result_fifo.sv
// Capture FIFO for the operand FSM: logs {state, rc} on every state change (FWFT, valid/ready out)
// and counts z_in cycles. Define RC_RESULT_FIFO_PARITY_EN to store an even-parity bit in out_data[6].
module rc_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic [3:0]                 rc_in,
  input  logic [1:0]                 state_in,
  input  logic                       z_in,
  input  logic                       out_ready,
  output logic                       out_valid,
`ifdef RC_RESULT_FIFO_PARITY_EN
  output logic [6:0]                 out_data,
`else
  output logic [5:0]                 out_data,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [CW-1:0]              z_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
`ifdef RC_RESULT_FIFO_PARITY_EN
  localparam int DW = 7;
`else
  localparam int DW = 6;
`endif

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [1:0]     last_state;
  logic [DW-1:0]  entry;
  logic           push;
  logic           pop;
  logic           accept;

`ifdef RC_RESULT_FIFO_PARITY_EN
  assign entry = {^{state_in, rc_in}, state_in, rc_in};
`else
  assign entry = {state_in, rc_in};
`endif

  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // clr suppresses both sides so a flush never races a transfer
  assign push   = (state_in != last_state) && !clr;
  assign pop    = out_valid && out_ready && !clr;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_state <= 2'b00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      z_cycles   <= '0;
    end else begin
      last_state <= state_in;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        z_cycles <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + AW'(1);
        if (pop)    rd_ptr <= rd_ptr + AW'(1);
        case ({accept, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
        if (push && !accept) overflow <= 1'b1;
        if (z_in && (z_cycles != '1)) z_cycles <= z_cycles + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rc_result_fifo.sv
// Directed bench for rc_result_fifo (DEPTH=4, CW=8); honours RC_RESULT_FIFO_PARITY_EN if defined.
module tb_rc_result_fifo;

`ifdef RC_RESULT_FIFO_PARITY_EN
  localparam int DW = 7;
`else
  localparam int DW = 6;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clr = 1'b0;
  logic [3:0]    rc_in = '0;
  logic [1:0]    state_in = '0;
  logic          z_in = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    z_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  rc_result_fifo #(.DEPTH(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .clr(clr), .rc_in(rc_in), .state_in(state_in),
    .z_in(z_in), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .z_cycles(z_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned ent(input logic [1:0] s, input logic [3:0] r);
`ifdef RC_RESULT_FIFO_PARITY_EN
    return 32'({^{s, r}, s, r});
`else
    return 32'({s, r});
`endif
  endfunction

  logic [1:0] dir_st [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  int unsigned drain_exp [5];

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_z", 32'(z_cycles), 0);
    chk("rst_data", 32'(out_data), 0);
    step();
    reset = 1'b1;
    step();

    // first push: 0 -> 1 with rc A
    state_in = 2'd1; rc_in = 4'hA;
    step();
    chk("p1_valid", 32'(out_valid), 1);
    chk("p1_data", 32'(out_data), ent(2'd1, 4'hA));
    chk("p1_count", 32'(count), 1);
    step();
    chk("p1_hold_data", 32'(out_data), ent(2'd1, 4'hA));
    chk("p1_hold_count", 32'(count), 1);

    // flush, landing last_state at 0 (state change on clr cycle must not push)
    clr = 1'b1; state_in = 2'd0;
    step();
    clr = 1'b0;
    chk("clr_count", 32'(count), 0);
    step();
    chk("clr_nopush", 32'(count), 0);

    // fill: states 1,2,3,0,1 with rc 1..5, fifth dropped
    for (int i = 0; i < 5; i++) begin
      state_in = dir_st[i]; rc_in = 4'(i + 1);
      step();
      if (i == 3) begin
        chk("fill_full4", 32'(full), 1);
        chk("fill_noovf", 32'(overflow), 0);
      end
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_head", 32'(out_data), ent(2'd1, 4'h1));

    // full + pop + push in same cycle
    out_ready = 1'b1; state_in = 2'd2; rc_in = 4'h6;
    step();
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_head", 32'(out_data), ent(2'd2, 4'h2));

    drain_exp = '{ent(2'd3, 4'h3), ent(2'd0, 4'h4), ent(2'd2, 4'h6), 0, 0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain%0d_data", i), 32'(out_data), drain_exp[i]);
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(3 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);

    // push and pop requested while empty
    state_in = 2'd3; rc_in = 4'h7;
    step();
    chk("emptypp_count", 32'(count), 1);
    chk("emptypp_data", 32'(out_data), ent(2'd3, 4'h7));
    step();
    chk("emptypp_popped", 32'(count), 0);
    out_ready = 1'b0;

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);

    // saturating z counter
    z_in = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("z_10", 32'(z_cycles), 10);
    for (int i = 0; i < 245; i++) step();
    chk("z_255", 32'(z_cycles), 255);
    for (int i = 0; i < 45; i++) step();
    chk("z_sat", 32'(z_cycles), 255);
    z_in = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("z_clr", 32'(z_cycles), 0);

    // async reset with 3 entries queued (last_state is 3)
    for (int i = 0; i < 3; i++) begin
      state_in = 2'(i); rc_in = 4'(8 + i);
      step();
    end
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_head", 32'(out_data), ent(2'd0, 4'h8));
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    state_in = 2'd0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_count", 32'(count), 0);

`ifdef RC_RESULT_FIFO_PARITY_EN
    state_in = 2'd3; rc_in = 4'h5;
    step();
    chk("par_35", 32'(out_data), 32'h35);
    out_ready = 1'b1; state_in = 2'd1; rc_in = 4'h0;
    step();
    chk("par_50", 32'(out_data), 32'h50);
    out_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc_result_fifo.md
# rc_result_fifo

Downstream capture stage for the 4-state operand FSM. It records the FSM's `RC` result and state code on every state transition into a first-word-fall-through FIFO. It counts cycles where the FSM's `output_bit` is high and hands entries to a consumer over a valid/ready handshake. It runs on the FSM's clock and sits between the FSM and the display/logging logic.

## Interface
- `DEPTH`, default 4: number of FIFO entries; power of two, 2..16.
- `CW`, default 8: width of the Z-cycle counter.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset (asserts while 0). Removal is synchronous to `clk`.
- `clr` input, 1 bit: synchronous flush of FIFO, overflow flag and counter.
- `rc_in` input, 4 bits: FSM `RC` result.
- `state_in` input, 2 bits: FSM `present_state` (0..3).
- `z_in` input, 1 bit: FSM `output_bit`.
- `out_ready` input, 1 bit: consumer accepts head entry.
- `out_valid` output, 1 bit: head entry present.
- `out_data` output, 6 bits (7 bits with parity): `{state, rc}` of head entry; `[6]` is parity when enabled.
- `count` output, clog2(DEPTH)+1 bits: current occupancy.
- `full` output, 1 bit: `count == DEPTH`.
- `empty` output, 1 bit: `count == 0`.
- `overflow` output, 1 bit: sticky; an entry was dropped.
- `z_cycles` output, CW bits: saturating count of cycles with `z_in == 1`.

## Operation
- Internal `last_state` register, reset value 2'b00, loads `state_in` every cycle.
- Push condition: `state_in != last_state`. The entry written is `{state_in, rc_in}`, sampled in that same cycle.
- Pop condition: `out_valid && out_ready`. The head pointer advances.
- Write and read pointers wrap modulo DEPTH. `count` tracks occupancy explicitly, so full and empty are never ambiguous.
- Push while full:
  - With a pop in the same cycle, the push is accepted and `count` is unchanged.
  - Without a pop, the entry is dropped and `overflow` is set to 1. It stays set until `clr` or reset.
- Push and pop both requested while empty: no pop occurs (`out_valid` = 0), the push is accepted, and `count` becomes 1.
- `z_cycles` increments on each cycle with `z_in == 1` and saturates at 2^CW−1 (no wrap).
- `clr` has priority over push, pop and counting in its cycle:
  - Pointers, `count`, `overflow` and `z_cycles` go to 0.
  - `last_state` still loads `state_in`, and no push occurs that cycle.
- Reset values: `out_valid` 0, `count` 0, `full` 0, `empty` 1, `overflow` 0, `z_cycles` 0, `out_data` 0, `last_state` 2'b00. FIFO storage is not reset.
- Reset asserted mid-operation discards all entries immediately, asynchronously, with no pending pop completing.

## Timing
- Push latency: an entry pushed at edge N into an empty FIFO gives `out_valid` = 1 and valid `out_data` after edge N. The consumer sees it in cycle N+1.
- `out_data` is driven combinationally from the head storage location (FWFT) and is 0 when empty.
- The consumer may hold `out_ready` high permanently, giving one pop per cycle. `out_data` must stay stable while `out_valid && !out_ready`.
- `count`, `full`, `empty`, `overflow` and `z_cycles` are registered and update one edge after the causing event.
- A state change sustained across consecutive cycles (e.g. 0→1→2) produces one entry per cycle.

## Configuration
- `RC_RESULT_FIFO_PARITY_EN` defined:
  - `out_data` is 7 bits.
  - Bit 6 is the even parity of bits 5:0, computed at write time and stored with the entry.
- Not defined: `out_data` is 6 bits and no parity storage is built.

## Test plan
- Reset then drive `state_in` 0→1 with `rc_in` = 4'hA, `out_ready` = 0 → one cycle later `out_valid` = 1, `out_data` = 6'h1A, `count` = 1.
- Drive states 1,2,3,0,1 on consecutive cycles with `out_ready` = 0 and DEPTH = 4 → 4 entries stored, `full` = 1, fifth entry dropped, `overflow` = 1.
- With the FIFO full, hold `out_ready` = 1 and change state once → `count` stays 4 and entries read in order with the new entry last.
- Hold `z_in` = 1 for 300 cycles with CW = 8 → `z_cycles` = 255 and stays there. Pulse `clr` → 0.
- Assert `reset` low mid-stream with 3 entries queued → `out_valid` drops to 0 and `count` = 0 without waiting for a clock edge.
- With parity enabled, push `{2'b11, 4'h5}` → `out_data` = 7'h35 (bit 6 = 0). Push `{2'b01, 4'h0}` → 7'h50.
